track_sequencer: RTL and testbench

Top-level navigation controller for the line-following car. It reads the three IR line sensors, detects intersections, and steps through a preloaded route of turn decisions. It drives the 5-bit mode bus consumed by the motor block. It owns the full run sequence (start delay, line following, turn choice, turn completion, stop and fault) so the motor block stays a pure mode-to-PWM mapper.

---
 rtl/track_pkg.sv | 49 ++++
 rtl/line_sensor_filter.sv | 69 ++++++
 rtl/track_sequencer.sv | 157 +++++++++++++++
 tb/tb_track_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// ---------------------------------------------------------------------------
// track_pkg
// Shared definitions for the line-following car navigation controller.
//   - MODE_*  : 5-bit mode bus encodings. The motor block imports the same
//               constants, so the two sides cannot disagree on an encoding.
//   - DIR_*   : route entry direction codes.
//   - TMR_W   : width of every run timer.
//   - state_t : sequencer state; each state's value is its mode encoding,
//               which is why the mode output is simply the state register.
//   - tmr_inc_sat : timer increment that sticks at all-ones instead of wrapping.
// ---------------------------------------------------------------------------
package track_pkg;

    localparam int TMR_W = 32;

    localparam logic [4:0] MODE_IDLE          = 5'd0;
    localparam logic [4:0] MODE_START         = 5'd1;
    localparam logic [4:0] MODE_COUNT         = 5'd2;
    localparam logic [4:0] MODE_STRAIGHT      = 5'd3;
    localparam logic [4:0] MODE_CHOOSE        = 5'd4;
    localparam logic [4:0] MODE_TURN_STRAIGHT = 5'd5;
    localparam logic [4:0] MODE_TURN_LEFT     = 5'd6;
    localparam logic [4:0] MODE_TURN_RIGHT    = 5'd7;
    localparam logic [4:0] MODE_STOP          = 5'd30;
    localparam logic [4:0] MODE_ERROR         = 5'd31;

    localparam logic [1:0] DIR_STRAIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT     = 2'b01;
    localparam logic [1:0] DIR_RIGHT    = 2'b10;
    localparam logic [1:0] DIR_STOP     = 2'b11;

    typedef enum logic [4:0] {
        ST_IDLE          = MODE_IDLE,
        ST_START         = MODE_START,
        ST_COUNT         = MODE_COUNT,
        ST_STRAIGHT      = MODE_STRAIGHT,
        ST_CHOOSE        = MODE_CHOOSE,
        ST_TURN_STRAIGHT = MODE_TURN_STRAIGHT,
        ST_TURN_LEFT     = MODE_TURN_LEFT,
        ST_TURN_RIGHT    = MODE_TURN_RIGHT,
        ST_STOP          = MODE_STOP,
        ST_ERROR         = MODE_ERROR
    } state_t;

    function automatic logic [TMR_W-1:0] tmr_inc_sat(input logic [TMR_W-1:0] t);
        return (t == '1) ? t : t + TMR_W'(1);
    endfunction

endpackage

// File: rtl/line_sensor_filter.sv
// ---------------------------------------------------------------------------
// line_sensor_filter
// Brings the asynchronous IR sensor pattern into the clock domain and only
// passes on a new pattern once it has been stable long enough.
//   clk  in   system clock
//   rst  in   asynchronous active-high reset (output returns to 000)
//   raw  in   {left,mid,right} sensors straight from the pins
//   filt out  debounced pattern; changes DEBOUNCE cycles after the
//             synchronized value last changed (2+DEBOUNCE from the pin)
// ---------------------------------------------------------------------------
module line_sensor_filter
    import track_pkg::*;
#(
    parameter int DEBOUNCE = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw,
    output logic [2:0] filt
);

    localparam logic [TMR_W-1:0] CNT_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] DEB_LIM    = TMR_W'(DEBOUNCE);
    localparam logic [TMR_W-1:0] DEB_LIM_M1 = TMR_W'(DEBOUNCE - 1);

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       cand_q, cand_d;
    logic [2:0]       filt_q, filt_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;

    // cand_q is the pattern currently being timed; cnt_q is how many
    // consecutive cycles sync2_q has shown it. The counter stops at
    // DEBOUNCE so a long-stable input never wraps back through the window.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_ONE;
        end else begin
            if (cnt_q < DEB_LIM) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (cnt_q >= DEB_LIM_M1) begin
                filt_d = cand_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            cand_q  <= 3'b000;
            cnt_q   <= '0;
            filt_q  <= 3'b000;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/track_sequencer.sv
// ---------------------------------------------------------------------------
// track_sequencer
// Navigation controller for the line-following car: runs the start delay,
// follows the line, picks each turn from a preloaded route and detects
// lost-line / stuck-turn faults. The mode output is the state register.
//   clk        in   system clock (100 MHz)
//   rst        in   asynchronous active-high reset; clears the route to STOP
//   start      in   single-cycle start / restart pulse
//   sensor     in   {left,mid,right} IR sensors, asynchronous, 1 = black
//   route_we   in   route write strobe (honoured in IDLE, STOP, ERROR only)
//   route_addr in   route entry index
//   route_dir  in   route entry: 00 straight, 01 left, 10 right, 11 stop
//   mode       out  motor mode command (registered)
//   route_idx  out  index of the next route entry to consume
//   done       out  high in STOP
//   err        out  high in ERROR
// ---------------------------------------------------------------------------
module track_sequencer
    import track_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int START_DELAY = 100_000_000,
    parameter int DEBOUNCE    = 50_000,
    parameter int TURN_MIN    = 20_000_000,
    parameter int TURN_MAX    = 300_000_000,
    parameter int LOST_LIMIT  = 200_000_000,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    sensor,
    input  logic          route_we,
    input  logic [AW-1:0] route_addr,
    input  logic [1:0]    route_dir,
    output logic [4:0]    mode,
    output logic [AW-1:0] route_idx,
    output logic          done,
    output logic          err
);

    localparam logic [TMR_W-1:0] START_M1    = TMR_W'(START_DELAY - 1);
    localparam logic [TMR_W-1:0] TURN_MIN_M1 = TMR_W'(TURN_MIN - 1);
    localparam logic [TMR_W-1:0] TURN_MAX_M1 = TMR_W'(TURN_MAX - 1);
    localparam logic [TMR_W-1:0] LOST_M1     = TMR_W'(LOST_LIMIT - 1);
    localparam logic [AW-1:0]    IDX_LAST    = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [AW-1:0]    route_idx_q, route_idx_d;
    logic             end_q, end_d;   // route consumed past its last entry
    logic [1:0]       route_q [DEPTH];
    logic [2:0]       filt;
    logic             is_turn;
    logic             wr_en;

    line_sensor_filter #(
        .DEBOUNCE (DEBOUNCE)
    ) u_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (sensor),
        .filt (filt)
    );

    assign is_turn = (state_q == ST_TURN_STRAIGHT) || (state_q == ST_TURN_LEFT) ||
                     (state_q == ST_TURN_RIGHT);

    // Route may only change while the car is parked.
    assign wr_en = route_we && (32'(route_addr) < 32'(DEPTH)) &&
                   ((state_q == ST_IDLE) || (state_q == ST_STOP) || (state_q == ST_ERROR));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_STOP, ST_ERROR: begin
                if (start) state_d = ST_START;
            end
            ST_START: state_d = ST_COUNT;
            ST_COUNT: begin
                if (tmr_q >= START_M1) state_d = ST_STRAIGHT;
            end
            ST_STRAIGHT: begin
                // Here the timer only accumulates consecutive 000 cycles.
                if (filt == 3'b111)                         state_d = ST_CHOOSE;
                else if (filt == 3'b000 && tmr_q >= LOST_M1) state_d = ST_ERROR;
            end
            ST_CHOOSE: begin
                if (end_q) begin
                    state_d = ST_STOP;
                end else begin
                    case (route_q[route_idx_q])
                        DIR_STRAIGHT: state_d = ST_TURN_STRAIGHT;
                        DIR_LEFT:     state_d = ST_TURN_LEFT;
                        DIR_RIGHT:    state_d = ST_TURN_RIGHT;
                        default:      state_d = ST_STOP;
                    endcase
                end
            end
            ST_TURN_STRAIGHT, ST_TURN_LEFT, ST_TURN_RIGHT: begin
                // Exit is checked first so it beats a coincident timeout.
                if (tmr_q >= TURN_MIN_M1 && filt == 3'b010) state_d = ST_STRAIGHT;
                else if (tmr_q >= TURN_MAX_M1)               state_d = ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (state_d != state_q)
            tmr_d = '0;
        else if (state_q == ST_STRAIGHT && filt != 3'b000)
            tmr_d = '0;
        else
            tmr_d = tmr_inc_sat(tmr_q);
    end

    always_comb begin
        route_idx_d = route_idx_q;
        end_d       = end_q;
        if (state_d == ST_START && state_q != ST_START) begin
            route_idx_d = '0;
            end_d       = 1'b0;
        end else if (is_turn && state_d == ST_STRAIGHT) begin
            if (route_idx_q == IDX_LAST) end_d = 1'b1;
            else                         route_idx_d = route_idx_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            route_idx_q <= '0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            route_idx_q <= route_idx_d;
            end_q       <= end_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) route_q[i] <= DIR_STOP;
        end else if (wr_en) begin
            route_q[route_addr] <= route_dir;
        end
    end

    assign mode      = state_q;
    assign route_idx = route_idx_q;
    assign done      = (state_q == ST_STOP);
    assign err       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_track_sequencer.sv
module tb_track_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic       route_we = 1'b0;
    logic [1:0] route_addr = 2'd0;
    logic [1:0] route_dir = 2'd0;
    logic [4:0] mode;
    logic [1:0] route_idx;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    track_sequencer #(
        .DEPTH       (4),
        .START_DELAY (10),
        .DEBOUNCE    (4),
        .TURN_MIN    (8),
        .TURN_MAX    (50),
        .LOST_LIMIT  (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sensor     (sensor),
        .route_we   (route_we),
        .route_addr (route_addr),
        .route_dir  (route_dir),
        .mode       (mode),
        .route_idx  (route_idx),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sens;
        logic [4:0] mode;
        int         lat;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Drive a sensor pattern, then count cycles until mode reaches m.
    task automatic step(input logic [2:0] s, input logic [4:0] m, input int lat,
                        input logic [1:0] idx);
        int n;
        sensor = s;
        n = 0;
        while (mode !== m && n < lat + 20) begin
            tick();
            n++;
        end
        chk($sformatf("mode->%0d", m), int'(mode), int'(m));
        chk($sformatf("latency->%0d", m), n, lat);
        chk($sformatf("route_idx@%0d", m), int'(route_idx), int'(idx));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start->mode", int'(mode), 1);
        chk("start->idx", int'(route_idx), 0);
    endtask

    task automatic write_route(input logic [1:0] a, input logic [1:0] d);
        route_we   = 1'b1;
        route_addr = a;
        route_dir  = d;
        tick();
        route_we   = 1'b0;
    endtask

    initial begin
        int stray;

        tbl[0]  = '{3'b111, 5'd4,  7, 2'd0};
        tbl[1]  = '{3'b111, 5'd6,  1, 2'd0};
        tbl[2]  = '{3'b010, 5'd3,  8, 2'd1};
        tbl[3]  = '{3'b111, 5'd4,  7, 2'd1};
        tbl[4]  = '{3'b111, 5'd7,  1, 2'd1};
        tbl[5]  = '{3'b010, 5'd3,  8, 2'd2};
        tbl[6]  = '{3'b111, 5'd4,  7, 2'd2};
        tbl[7]  = '{3'b111, 5'd5,  1, 2'd2};
        tbl[8]  = '{3'b010, 5'd3,  8, 2'd3};
        tbl[9]  = '{3'b111, 5'd4,  7, 2'd3};
        tbl[10] = '{3'b111, 5'd30, 1, 2'd3};

        // Reset state
        sensor = 3'b010;
        #2 rst = 1'b1;
        tick(); tick(); tick();
        chk("rst mode", int'(mode), 0);
        chk("rst idx", int'(route_idx), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst route[%0d]", i), int'(dut.route_q[i]), 3);
        rst = 1'b0;
        tick();

        // Load route {01,10,00,11}; entry 2 is written together with start
        write_route(2'd0, 2'b01);
        write_route(2'd1, 2'b10);
        write_route(2'd3, 2'b11);
        route_we = 1'b1; route_addr = 2'd2; route_dir = 2'b00;
        pulse_start();
        route_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("count cyc %0d", i), int'(mode), 2);
        end
        tick();
        chk("after count", int'(mode), 3);
        chk("after count idx", int'(route_idx), 0);

        // Full route run from the table
        for (int i = 0; i < 11; i++) step(tbl[i].sens, tbl[i].mode, tbl[i].lat, tbl[i].idx);
        chk("stop done", int'(done), 1);
        chk("stop err", int'(err), 0);

        // Re-run; start ignored in STRAIGHT; 3-cycle 111 glitch filtered
        sensor = 3'b010;
        pulse_start();
        step(3'b010, 5'd3, 11, 2'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start ignored", int'(mode), 3);
        sensor = 3'b111;
        tick(); tick(); tick();
        sensor = 3'b010;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mode != 5'd3) stray++;
        end
        chk("glitch stays straight", stray, 0);

        // 111 held 4 cycles then 010: filtered 010 already present early in TURN
        sensor = 3'b111;
        tick(); tick(); tick(); tick();
        chk("no early choose", int'(mode), 3);
        sensor = 3'b010;
        tick(); tick(); tick();
        chk("held 111 choose", int'(mode), 4);
        tick();
        chk("turn left", int'(mode), 6);
        step(3'b010, 5'd3, 8, 2'd1);

        // Turn timeout
        step(3'b111, 5'd4, 7, 2'd1);
        step(3'b111, 5'd7, 1, 2'd1);
        step(3'b111, 5'd31, 50, 2'd1);
        chk("timeout err", int'(err), 1);
        chk("timeout done", int'(done), 0);
        sensor = 3'b010;
        pulse_start();
        step(3'b010, 5'd3, 11, 2'd0);

        // Lost line
        step(3'b000, 5'd31, 26, 2'd0);
        chk("lost err", int'(err), 1);
        sensor = 3'b010;
        pulse_start();
        step(3'b010, 5'd3, 11, 2'd0);
        sensor = 3'b000;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 15) sensor = 3'b010;
            if (i == 19) sensor = 3'b000;
            tick();
            if (mode != 5'd3) stray++;
        end
        chk("lost timer restarted", stray, 0);
        step(3'b000, 5'd31, 15, 2'd0);

        // Route write ignored while running; async reset in TURN_RIGHT
        sensor = 3'b010;
        pulse_start();
        step(3'b010, 5'd3, 11, 2'd0);
        write_route(2'd0, 2'b10);
        chk("write ignored", int'(dut.route_q[0]), 1);
        step(3'b111, 5'd4, 7, 2'd0);
        step(3'b111, 5'd6, 1, 2'd0);
        step(3'b010, 5'd3, 8, 2'd1);
        step(3'b111, 5'd4, 7, 2'd1);
        step(3'b111, 5'd7, 1, 2'd1);
        #3 rst = 1'b1;
        #1;
        chk("async rst mode", int'(mode), 0);
        chk("async rst idx", int'(route_idx), 0);
        chk("async rst err", int'(err), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("async rst route[%0d]", i), int'(dut.route_q[i]), 3);
        tick();
        rst = 1'b0;
        tick();

        // Route end saturation: four straight-through entries, fifth CHOOSE stops
        sensor = 3'b010;
        for (int i = 0; i < 4; i++) write_route(2'(i), 2'b00);
        pulse_start();
        step(3'b010, 5'd3, 11, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step(3'b111, 5'd4, 7, 2'(i));
            step(3'b111, 5'd5, 1, 2'(i));
            step(3'b010, 5'd3, 8, (i == 3) ? 2'd3 : 2'(i + 1));
        end
        step(3'b111, 5'd4, 7, 2'd3);
        step(3'b111, 5'd30, 1, 2'd3);
        chk("end done", int'(done), 1);
        pulse_start();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
